// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: arbitrates the register file write port between the
// pipeline writeback stage (always first) and buffered long-unit results.
// A scoreboard marks registers that still have a long-unit write pending.
// A starvation counter asks the pipeline to insert a bubble when buffered
// results have been blocked for too long.
module regfile_wb_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 5,
    parameter int BUF_DEPTH    = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic                  lu_issue,
    input  logic [ADDR_WIDTH-1:0] lu_issue_addr,
    input  logic                  lu_valid,
    input  logic [ADDR_WIDTH-1:0] lu_addr,
    input  logic [DATA_WIDTH-1:0] lu_data,
    output logic                  lu_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic                  busy_1,
    output logic                  busy_2,
    output logic                  busy_issue,
    output logic                  wb_hold,
    output logic                  rf_we,
    output logic [ADDR_WIDTH-1:0] rf_addr,
    output logic [DATA_WIDTH-1:0] rf_data
);

    localparam int PTR_W    = $clog2(BUF_DEPTH);
    localparam int CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam int NREG     = 1 << ADDR_WIDTH;

    logic [ADDR_WIDTH-1:0] buf_addr_q [BUF_DEPTH];
    logic [DATA_WIDTH-1:0] buf_data_q [BUF_DEPTH];

    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [NREG-1:0]     busy_q, busy_d;
    logic [STARVE_W-1:0] starve_q, starve_d;
    logic                wb_hold_q, wb_hold_d;

    logic                  pipe_occ;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  push;
    logic                  pop;
    logic [ADDR_WIDTH-1:0] head_addr;
    logic [DATA_WIDTH-1:0] head_data;

    // Handshake and port-ownership decisions derived from registered FIFO state
    always_comb begin
        pipe_occ   = wb_we && (wb_addr != '0);
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == CNT_W'(BUF_DEPTH));
        head_addr  = buf_addr_q[rd_ptr_q];
        head_data  = buf_data_q[rd_ptr_q];
        push       = lu_valid && !fifo_full && (lu_addr != '0);
        pop        = !pipe_occ && !fifo_empty;
        lu_ready   = !fifo_full;
        busy_1     = busy_q[rd_addr_1];
        busy_2     = busy_q[rd_addr_2];
        busy_issue = busy_q[lu_issue_addr];
        wb_hold    = wb_hold_q;
    end

    // Write-port mux: pipeline first, then the FIFO head, otherwise idle (forced idle in reset)
    always_comb begin
        rf_we   = 1'b0;
        rf_addr = '0;
        rf_data = '0;
        if (!rst) begin
            if (pipe_occ) begin
                rf_we   = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (!fifo_empty) begin
                rf_we   = 1'b1;
                rf_addr = head_addr;
                rf_data = head_data;
            end
        end
    end

    // Next-state for pointers, occupancy, scoreboard and starvation tracking
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);

        busy_d = busy_q;
        if (pop) begin
            busy_d[head_addr] = 1'b0;
        end
        if (lu_issue) begin
            busy_d[lu_issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;

        starve_d = starve_q;
        if (pop || fifo_empty) begin
            starve_d = '0;
        end else if (pipe_occ && (starve_q != STARVE_W'(STARVE_LIMIT))) begin
            starve_d = starve_q + STARVE_W'(1);
        end
        wb_hold_d = (starve_d == STARVE_W'(STARVE_LIMIT));
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            busy_q    <= '0;
            starve_q  <= '0;
            wb_hold_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            starve_q  <= starve_d;
            wb_hold_q <= wb_hold_d;
        end
    end

    // Result storage; contents are only meaningful where the count says so
    always_ff @(posedge clk) begin
        if (push) begin
            buf_addr_q[wr_ptr_q] <= lu_addr;
            buf_data_q[wr_ptr_q] <= lu_data;
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a queue-based model.
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clk;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        lu_issue;
    logic [4:0]  lu_issue_addr;
    logic        lu_valid;
    logic [4:0]  lu_addr;
    logic [31:0] lu_data;
    logic        lu_ready;
    logic [4:0]  rd_addr_1;
    logic [4:0]  rd_addr_2;
    logic        busy_1;
    logic        busy_2;
    logic        busy_issue;
    logic        wb_hold;
    logic        rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    regfile_wb_arbiter #(
        .DATA_WIDTH(32), .ADDR_WIDTH(5), .BUF_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .lu_issue(lu_issue), .lu_issue_addr(lu_issue_addr),
        .lu_valid(lu_valid), .lu_addr(lu_addr), .lu_data(lu_data),
        .lu_ready(lu_ready),
        .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .busy_1(busy_1), .busy_2(busy_2), .busy_issue(busy_issue),
        .wb_hold(wb_hold),
        .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Behavioural model: a queue of pending results, a busy bit per register,
    // and a count of consecutive blocked cycles.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t q[$];
    bit   busy_m[32];
    int   starve_m;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss;
        logic [4:0]  ia;
        logic        lv;
        logic [4:0]  la;
        logic [31:0] ld;
        logic [4:0]  r1;
        logic [4:0]  r2;
        logic        e_we;
        logic [4:0]  e_a;
        logic [31:0] e_d;
        logic        e_rdy;
        logic        e_b1;
        logic        e_b2;
        logic        e_bi;
        logic        e_hold;
    } vec_t;
    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        foreach (busy_m[i]) busy_m[i] = 1'b0;
        starve_m = 0;
    endtask

    task automatic model_compare();
        logic        pipe;
        logic        ew;
        logic [4:0]  ea;
        logic [31:0] ed;
        pipe = wb_we && (wb_addr != 0);
        ew = 1'b0; ea = '0; ed = '0;
        if (pipe) begin
            ew = 1'b1; ea = wb_addr; ed = wb_data;
        end else if (q.size() > 0) begin
            ew = 1'b1; ea = q[0].a; ed = q[0].d;
        end
        check("model_rf_we", rf_we, ew);
        check("model_rf_addr", rf_addr, ea);
        check("model_rf_data", rf_data, ed);
        check("model_lu_ready", lu_ready, q.size() < DEPTH);
        check("model_busy_1", busy_1, busy_m[rd_addr_1]);
        check("model_busy_2", busy_2, busy_m[rd_addr_2]);
        check("model_busy_issue", busy_issue, busy_m[lu_issue_addr]);
        check("model_wb_hold", wb_hold, starve_m == LIMIT);
    endtask

    task automatic model_step();
        logic pipe;
        bit   was_empty;
        bit   popped;
        bit   accept;
        pipe      = wb_we && (wb_addr != 0);
        was_empty = (q.size() == 0);
        popped    = !pipe && !was_empty;
        accept    = lu_valid && (q.size() < DEPTH);
        if (popped) begin
            busy_m[q[0].a] = 1'b0;
            void'(q.pop_front());
        end
        if (accept && lu_addr != 0) q.push_back('{lu_addr, lu_data});
        if (lu_issue && lu_issue_addr != 0) busy_m[lu_issue_addr] = 1'b1;
        if (popped || was_empty) starve_m = 0;
        else if (starve_m < LIMIT) starve_m++;
    endtask

    task automatic tick();
        @(negedge clk);
        model_compare();
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    task automatic set_idle();
        wb_we = 0; wb_addr = 0; wb_data = 0;
        lu_issue = 0; lu_issue_addr = 0;
        lu_valid = 0; lu_addr = 0; lu_data = 0;
        rd_addr_1 = 0; rd_addr_2 = 0;
    endtask

    initial begin
        rst = 1'b1;
        set_idle();
        rd_addr_1 = 5;
        model_reset();
        #2;
        check("reset_rf_we", rf_we, 0);
        check("reset_rf_addr", rf_addr, 0);
        check("reset_lu_ready", lu_ready, 1);
        check("reset_busy_1", busy_1, 0);
        check("reset_wb_hold", wb_hold, 0);
        #6 rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors: expectations are derived by hand
        vecs[0]  = '{0,0,0,            0,0, 0,0,0,            5,0, 0,0,0,            1,0,0,0,0};
        vecs[1]  = '{0,0,0,            1,5, 0,0,0,            5,0, 0,0,0,            1,0,0,0,0};
        vecs[2]  = '{0,0,0,            0,0, 0,0,0,            5,0, 0,0,0,            1,1,0,0,0};
        vecs[3]  = '{0,0,0,            0,0, 1,5,32'hDEADBEEF, 5,0, 0,0,0,            1,1,0,0,0};
        vecs[4]  = '{0,0,0,            0,0, 0,0,0,            5,0, 1,5,32'hDEADBEEF, 1,1,0,0,0};
        vecs[5]  = '{0,0,0,            0,0, 0,0,0,            5,0, 0,0,0,            1,0,0,0,0};
        vecs[6]  = '{0,0,0,            0,0, 1,4,32'h44,       4,0, 0,0,0,            1,0,0,0,0};
        vecs[7]  = '{1,0,32'h99,       0,0, 0,0,0,            4,0, 1,4,32'h44,       1,0,0,0,0};
        vecs[8]  = '{0,0,0,            1,6, 0,0,0,            0,6, 0,0,0,            1,0,0,0,0};
        vecs[9]  = '{0,0,0,            0,0, 1,6,32'h66,       0,6, 0,0,0,            1,0,1,0,0};
        vecs[10] = '{0,0,0,            1,6, 0,0,0,            0,6, 1,6,32'h66,       1,0,1,1,0};
        vecs[11] = '{0,0,0,            0,6, 0,0,0,            0,6, 0,0,0,            1,0,1,1,0};
        vecs[12] = '{0,0,0,            0,0, 1,0,32'h1234,     0,6, 0,0,0,            1,0,1,0,0};
        vecs[13] = '{0,0,0,            0,0, 0,0,0,            0,6, 0,0,0,            1,0,1,0,0};
        vecs[14] = '{1,3,32'h33,       0,0, 0,0,0,            0,0, 1,3,32'h33,       1,0,0,0,0};

        for (int i = 0; i < 15; i++) begin
            wb_we = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd;
            lu_issue = vecs[i].iss; lu_issue_addr = vecs[i].ia;
            lu_valid = vecs[i].lv; lu_addr = vecs[i].la; lu_data = vecs[i].ld;
            rd_addr_1 = vecs[i].r1; rd_addr_2 = vecs[i].r2;
            #1;
            check($sformatf("vec%0d_rf_we", i), rf_we, vecs[i].e_we);
            check($sformatf("vec%0d_rf_addr", i), rf_addr, vecs[i].e_a);
            check($sformatf("vec%0d_rf_data", i), rf_data, vecs[i].e_d);
            check($sformatf("vec%0d_lu_ready", i), lu_ready, vecs[i].e_rdy);
            check($sformatf("vec%0d_busy_1", i), busy_1, vecs[i].e_b1);
            check($sformatf("vec%0d_busy_2", i), busy_2, vecs[i].e_b2);
            check($sformatf("vec%0d_busy_issue", i), busy_issue, vecs[i].e_bi);
            check($sformatf("vec%0d_wb_hold", i), wb_hold, vecs[i].e_hold);
            tick();
        end

        // Pipeline holds the port while two results arrive, then yields
        set_idle();
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        lu_valid = 1; lu_addr = 7; lu_data = 32'h77;
        #1 check("starve_pipe_wins", rf_addr, 3);
        tick();
        lu_addr = 9; lu_data = 32'h99;
        #1 check("starve_ready_one", lu_ready, 1);
        tick();
        lu_valid = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("starve_ready_full", lu_ready, 0);
            check("starve_hold_low", wb_hold, 0);
            check("starve_rf_addr", rf_addr, 3);
            tick();
        end
        #1 check("starve_hold_high", wb_hold, 1);
        wb_we = 0;
        #1;
        check("drain_first_addr", rf_addr, 7);
        check("drain_first_data", rf_data, 32'h77);
        check("drain_hold_still", wb_hold, 1);
        tick();
        check("drain_second_addr", rf_addr, 9);
        check("drain_hold_fell", wb_hold, 0);
        tick();
        check("drain_done", rf_we, 0);

        // Full FIFO with a held result, then a single pop
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        lu_valid = 1; lu_addr = 10; lu_data = 32'hA0;
        tick();
        lu_addr = 11; lu_data = 32'hA1;
        tick();
        lu_addr = 12; lu_data = 32'hA2;
        for (int i = 0; i < 3; i++) begin
            #1 check("held_ready_low", lu_ready, 0);
            tick();
        end
        wb_we = 0;
        #1;
        check("held_pop_ready_low", lu_ready, 0);
        check("held_pop_addr", rf_addr, 10);
        tick();
        wb_we = 1;
        check("held_ready_rises", lu_ready, 1);
        tick();
        lu_valid = 0; wb_we = 0;
        #1 check("held_second_addr", rf_addr, 11);
        tick();
        check("held_third_addr", rf_addr, 12);
        check("held_third_data", rf_data, 32'hA2);
        tick();
        check("held_empty", rf_we, 0);

        // Asynchronous reset in the middle of a drain
        wb_we = 1; wb_addr = 3; wb_data = 32'h33;
        lu_valid = 1; lu_addr = 13; lu_data = 32'hD13;
        lu_issue = 1; lu_issue_addr = 13;
        tick();
        lu_addr = 14; lu_data = 32'hD14; lu_issue_addr = 14;
        tick();
        set_idle();
        rd_addr_1 = 14; rd_addr_2 = 13;
        #1 check("rst_drain_first", rf_addr, 13);
        tick();
        check("rst_drain_second", rf_addr, 14);
        check("rst_busy_before", busy_1, 1);
        rst = 1'b1;
        #1;
        check("rst_async_rf_we", rf_we, 0);
        check("rst_async_lu_ready", lu_ready, 1);
        check("rst_async_busy_1", busy_1, 0);
        check("rst_async_wb_hold", wb_hold, 0);
        #2 rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1 check("rst_after_empty", rf_we, 0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            wb_we = ($urandom_range(0, 2) != 0);
            wb_addr = 5'($urandom_range(0, 7));
            wb_data = $urandom;
            lu_issue = ($urandom_range(0, 2) == 0);
            lu_issue_addr = 5'($urandom_range(0, 7));
            lu_valid = ($urandom_range(0, 1) == 0);
            lu_addr = 5'($urandom_range(0, 7));
            lu_data = $urandom;
            rd_addr_1 = 5'($urandom_range(0, 7));
            rd_addr_2 = 5'($urandom_range(0, 31));
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
